// File: rtl/fnd_pkg.sv
// Shared definitions for the FND (7-segment) receive path: font codes and capture FSM states.
package fnd_pkg;

    localparam int unsigned FND_DIGITS = 4;

    // Active-low {dp,g,f,e,d,c,b,a} with dp forced high.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] DP_MASK    = 8'h80;

    typedef enum logic {COLLECT, CONVERT} fnd_cap_state_e;

    function automatic logic [13:0] bcd4_to_bin(input logic [3:0][3:0] d);
        return 14'(d[3]) * 14'd1000 + 14'(d[2]) * 14'd100 + 14'(d[1]) * 14'd10 + 14'(d[0]);
    endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational segment-font to BCD decoder; the dp segment is ignored.
module fnd_font_decoder
    import fnd_pkg::*;
(
    input  logic [7:0] font_i,
    output logic [3:0] bcd_o,
    output logic       legal_o
);

    always_comb begin
        bcd_o   = 4'd0;
        legal_o = 1'b1;
        case (font_i | DP_MASK)
            FONT_0:  bcd_o = 4'd0;
            FONT_1:  bcd_o = 4'd1;
            FONT_2:  bcd_o = 4'd2;
            FONT_3:  bcd_o = 4'd3;
            FONT_4:  bcd_o = 4'd4;
            FONT_5:  bcd_o = 4'd5;
            FONT_6:  bcd_o = 4'd6;
            FONT_7:  bcd_o = 4'd7;
            FONT_8:  bcd_o = 4'd8;
            FONT_9:  bcd_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_capture.sv
// Receive side of a multiplexed 4-digit FND bus: samples settled digits, assembles a frame
// and reports it as a binary number.
module fnd_capture
    import fnd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fndCom,
    input  logic [7:0]  fndFont,
    output logic [13:0] number,
    output logic        number_valid,
    output logic        font_err,
    output logic        frame_err
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_CYCLES - 1);

    logic [3:0]       com_q;
    logic [7:0]       font_q;
    logic [11:0]      prev_q;
    logic [CntW-1:0]  stable_cnt_q, stable_cnt_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [3:0]       mask_q, mask_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [13:0]      number_q, number_d;
    fnd_cap_state_e   state_q, state_d;

    logic       same;
    logic       sample;
    logic       one_low;
    logic [1:0] idx;
    logic [3:0] bcd;
    logic       legal;
    logic       samp_ok;

    fnd_font_decoder u_dec (
        .font_i  (font_q),
        .bcd_o   (bcd),
        .legal_o (legal)
    );

    assign same    = ({com_q, font_q} == prev_q);
    // Fires on the single cycle the counter steps onto its saturation value.
    assign sample  = same && (stable_cnt_q == CntMax - CntW'(1));
    assign one_low = ($countones(~com_q) == 1);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < FND_DIGITS; i++) begin
            if (!com_q[i]) idx = 2'(i);
        end
    end

    always_comb begin
        if (!same)                   stable_cnt_d = '0;
        else if (stable_cnt_q != CntMax) stable_cnt_d = stable_cnt_q + CntW'(1);
        else                         stable_cnt_d = stable_cnt_q;
    end

    always_comb begin
        digit_d      = digit_q;
        mask_d       = mask_q;
        timer_d      = timer_q;
        number_d     = number_q;
        state_d      = state_q;
        number_valid = 1'b0;
        font_err     = 1'b0;
        frame_err    = 1'b0;
        samp_ok      = 1'b0;

        if (sample && (com_q != 4'b1111)) begin
            if (!one_low)   frame_err = 1'b1;
            else if (legal) samp_ok   = 1'b1;
            else            font_err  = 1'b1;
        end

        unique case (state_q)
            COLLECT: begin
                timer_d = (mask_q != 4'b0000) ? timer_q + TmrW'(1) : '0;
                if (font_err || frame_err) begin
                    mask_d  = 4'b0000;
                    timer_d = '0;
                end else if ((mask_q != 4'b0000) && (timer_q == TmrMax)) begin
                    frame_err = 1'b1;
                    mask_d    = 4'b0000;
                    timer_d   = '0;
                end else begin
                    if (samp_ok) begin
                        digit_d[idx] = bcd;
                        mask_d[idx]  = 1'b1;
                    end
                    if (mask_q == 4'b1111) begin
                        number_d = bcd4_to_bin(digit_q);
                        state_d  = CONVERT;
                    end
                end
            end
            CONVERT: begin
                number_valid = 1'b1;
                mask_d       = 4'b0000;
                timer_d      = '0;
                state_d      = COLLECT;
                if (samp_ok) begin
                    digit_d[idx] = bcd;
                    mask_d[idx]  = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_q        <= 4'b1111;
            font_q       <= FONT_BLANK;
            prev_q       <= {4'b1111, FONT_BLANK};
            stable_cnt_q <= '0;
            digit_q      <= '0;
            mask_q       <= 4'b0000;
            timer_q      <= '0;
            number_q     <= 14'd0;
            state_q      <= COLLECT;
        end else begin
            com_q        <= fndCom;
            font_q       <= fndFont;
            prev_q       <= {com_q, font_q};
            stable_cnt_q <= stable_cnt_d;
            digit_q      <= digit_d;
            mask_q       <= mask_d;
            timer_q      <= timer_d;
            number_q     <= number_d;
            state_q      <= state_d;
        end
    end

    assign number = number_q;

endmodule

// File: tb/tb_fnd_capture.sv
// Directed bench for fnd_capture: expected frame values queued at drive time, checked on pulses.
module tb_fnd_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic [13:0] number;
    logic        number_valid;
    logic        font_err;
    logic        frame_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    int          frerr_cnt = 0;
    int          cyc = 0;
    int          frerr_cyc = 0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_v;
    logic [7:0]  font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_capture #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fndCom       (fndCom),
        .fndFont      (fndFont),
        .number       (number),
        .number_valid (number_valid),
        .font_err     (font_err),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (number_valid) begin
            valid_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $error("FAIL unexpected_valid: observed number %0d, required no pulse", number);
            end else begin
                exp_v = exp_q.pop_front();
                assert (number === exp_v) else begin
                    n_bad++;
                    $error("FAIL frame_value: observed %0d required %0d", number, exp_v);
                end
            end
        end
        if (font_err) ferr_cnt++;
        if (frame_err) begin
            frerr_cnt++;
            frerr_cyc = cyc;
        end
        if (font_err && frame_err) begin
            n_cmp++;
            n_bad++;
            $error("FAIL err_exclusive: observed both error pulses, required at most one");
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] com, input logic [7:0] font, input int n);
        fndCom  = com;
        fndFont = font;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] f3, input logic [7:0] f2,
                         input logic [7:0] f1, input logic [7:0] f0);
        show(4'b0111, f3, 8);
        show(4'b1011, f2, 8);
        show(4'b1101, f1, 8);
        show(4'b1110, f0, 8);
        show(4'b1111, 8'hFF, 6);
    endtask

    task automatic frame_num(input int v);
        exp_q.push_back(14'(v));
        frame(font_tab[(v / 1000) % 10], font_tab[(v / 100) % 10],
              font_tab[(v / 10) % 10], font_tab[v % 10]);
    endtask

    int v0, e0, f0, dcyc;

    initial begin
        reset   = 1'b0;
        fndCom  = 4'b1111;
        fndFont = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_number", int'(number), 0);
        check("rst_valid", int'(number_valid), 0);
        check("rst_font_err", int'(font_err), 0);
        check("rst_frame_err", int'(frame_err), 0);
        reset = 1'b1;
        show(4'b1111, 8'hFF, 4);

        // 1: basic frame
        v0 = valid_cnt;
        frame_num(1234);
        check("t1_pulses", valid_cnt - v0, 1);
        check("t1_number", int'(number), 1234);

        // 2: extremes
        v0 = valid_cnt;
        frame_num(0);
        check("t2_zero", int'(number), 0);
        frame_num(9999);
        check("t2_max", int'(number), 'h270F);
        check("t2_pulses", valid_cnt - v0, 2);

        // 3: illegal font
        v0 = valid_cnt;
        e0 = ferr_cnt;
        show(4'b0111, 8'hFF, 8);
        show(4'b1111, 8'hFF, 4);
        check("t3_font_err", ferr_cnt - e0, 1);
        check("t3_no_valid", valid_cnt - v0, 0);
        frame_num(42);
        check("t3_number", int'(number), 42);

        // 4: short digit ignored, dp-low font accepted
        v0 = valid_cnt;
        e0 = ferr_cnt;
        f0 = frerr_cnt;
        show(4'b1110, font_tab[5], 3);
        show(4'b1111, 8'hFF, 8);
        check("t4_no_valid", valid_cnt - v0, 0);
        check("t4_no_errs", (ferr_cnt - e0) + (frerr_cnt - f0), 0);
        check("t4_hold", int'(number), 42);
        exp_q.push_back(14'd123);
        frame(8'h40, font_tab[1], font_tab[2], font_tab[3]);
        check("t4_dp_number", int'(number), 123);

        // 5: illegal com, then reset mid-frame
        v0 = valid_cnt;
        f0 = frerr_cnt;
        show(4'b1100, font_tab[1], 8);
        show(4'b1111, 8'hFF, 4);
        check("t5_frame_err", frerr_cnt - f0, 1);
        check("t5_no_valid", valid_cnt - v0, 0);
        show(4'b0111, font_tab[9], 8);
        show(4'b1011, font_tab[9], 8);
        fndCom  = 4'b1111;
        fndFont = 8'hFF;
        reset   = 1'b0;
        #1;
        check("t5_rst_number", int'(number), 0);
        check("t5_rst_pulses", int'({number_valid, font_err, frame_err}), 0);
        show(4'b1111, 8'hFF, 2);
        reset = 1'b1;
        show(4'b1111, 8'hFF, 4);
        v0 = valid_cnt;
        frame_num(5678);
        check("t5_number", int'(number), 5678);
        check("t5_pulses", valid_cnt - v0, 1);

        // 6: timeout after three digits
        v0   = valid_cnt;
        f0   = frerr_cnt;
        dcyc = cyc;
        show(4'b0111, font_tab[5], 8);
        show(4'b1011, font_tab[6], 8);
        show(4'b1101, font_tab[7], 8);
        fndCom  = 4'b1111;
        fndFont = 8'hFF;
        for (int k = 0; k < 200 && frerr_cnt == f0; k++) @(negedge clk);
        check("t6_frame_err", frerr_cnt - f0, 1);
        check("t6_err_cycle", frerr_cyc - dcyc, 104);
        check("t6_no_valid", valid_cnt - v0, 0);
        show(4'b1111, 8'hFF, 4);
        frame_num(7);
        check("t6_number", int'(number), 7);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
